// File: rtl/handshake_pack_block.sv
`default_nettype none
// ============================================================================
// Module      : handshake_pack_block
// Description : Packs a valid/ready stream of narrow WIDTH-bit beats into
//               RATIO-lane wide words. A beat with in_last set closes the
//               current word early; out_keep marks which lanes hold beats.
//               The wide output is fully registered and uses valid/ready.
//
// Ports       : clk        - clock, all state on rising edge
//               rst        - asynchronous, active-high reset
//               in_valid   - narrow beat valid
//               in_ready   - narrow beat accepted when in_valid && in_ready
//               in_data    - narrow beat payload [WIDTH-1:0]
//               in_last    - beat closes the current wide word
//               out_valid  - wide word valid
//               out_ready  - wide word consumed when out_valid && out_ready
//               out_data   - wide word, lane k at [k*WIDTH +: WIDTH]
//               out_keep   - bit k set iff lane k holds a received beat
//               out_last   - word was closed by in_last
//
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_pack_block #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   out_last
);

    localparam int                 c_cnt_w   = $clog2(RATIO);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(RATIO - 1);

    // Partial-word storage: only RATIO-1 lanes are needed because the beat
    // that fills the top lane always closes the word and goes straight to
    // the output register.
    logic [WIDTH-1:0]       r_acc [RATIO-1];
    logic [c_cnt_w-1:0]     r_cnt;

    logic                   r_out_valid;
    logic [WIDTH*RATIO-1:0] r_out_data;
    logic [RATIO-1:0]       r_out_keep;
    logic                   r_out_last;

    logic                   w_slot_free;
    logic                   w_closing;
    logic                   w_accept;
    logic [WIDTH*RATIO-1:0] w_word_data;
    logic [RATIO-1:0]       w_word_keep;

    // The output slot is free if empty or being drained this cycle. Only a
    // closing beat needs the slot, so non-closing beats keep flowing into
    // the accumulator while the sink stalls.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_closing   = (r_cnt == c_cnt_max) || in_last;
    assign in_ready    = w_slot_free || !w_closing;
    assign w_accept    = in_valid && in_ready;

    // Per-lane assembly of the word formed by a closing beat: lanes below
    // cnt come from the accumulator, lane cnt is the incoming beat, lanes
    // above are zero so stale accumulator contents never reach out_data.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        localparam logic [c_cnt_w-1:0] c_k = c_cnt_w'(k);

        if (k == 0) begin : g_keep_first
            assign w_word_keep[k] = 1'b1;
        end else begin : g_keep_rest
            assign w_word_keep[k] = (r_cnt >= c_k);
        end

        if (k < RATIO - 1) begin : g_acc_lane
            assign w_word_data[k*WIDTH +: WIDTH] =
                (r_cnt > c_k)  ? r_acc[k] :
                (r_cnt == c_k) ? in_data  : '0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc[k] <= '0;
                end else if (w_accept && !w_closing && (r_cnt == c_k)) begin
                    r_acc[k] <= in_data;
                end
            end
        end else begin : g_top_lane
            assign w_word_data[k*WIDTH +: WIDTH] = (r_cnt == c_k) ? in_data : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_closing ? '0 : r_cnt + 1'b1;
            end

            // A new word may replace the one being consumed in the same
            // cycle, so back-to-back words leave no bubble.
            if (w_accept && w_closing) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word_data;
                r_out_keep  <= w_word_keep;
                r_out_last  <= in_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_handshake_pack_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_pack_block
// Description : Self-checking bench for handshake_pack_block (WIDTH=8,
//               RATIO=4). A queue-based model of the packing rules is checked
//               against the DUT on every cycle; directed tests add literal
//               expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_pack_block;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;

    typedef struct {
        logic [WIDTH*RATIO-1:0] data;
        logic [RATIO-1:0]       keep;
        logic                   last;
    } word_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   in_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]       out_keep;
    logic                   out_last;

    int total = 0;
    int bad   = 0;
    logic done = 1'b0;

    handshake_pack_block #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // part_q: beats of the word being assembled; exp_q: closed words not yet
    // consumed by the sink, oldest first.
    logic [WIDTH-1:0] part_q [$];
    word_t            exp_q  [$];
    logic             mon_prev_stall = 1'b0;
    logic [63:0]      mon_prev_word  = '0;
    logic             mon_closing;
    logic             mon_busy;
    word_t            mon_w;
    word_t            mon_nw;

    always @(negedge clk) begin
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            mon_prev_stall = 1'b0;
        end else begin
            mon_closing = (part_q.size() == RATIO - 1) || in_last;
            mon_busy    = (exp_q.size() != 0) && !out_ready;
            chk("in_ready", 64'(in_ready), 64'(!mon_busy || !mon_closing));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (mon_prev_stall)
                chk("stall_hold", 64'({out_data, out_keep, out_last}), mon_prev_word);
            if (out_valid && exp_q.size() != 0) begin
                mon_w = exp_q[0];
                chk("word", 64'({out_data, out_keep, out_last}),
                    64'({mon_w.data, mon_w.keep, mon_w.last}));
                if (out_ready) void'(exp_q.pop_front());
            end
            mon_prev_stall = out_valid && !out_ready;
            mon_prev_word  = 64'({out_data, out_keep, out_last});
            if (in_valid && in_ready) begin
                part_q.push_back(in_data);
                if (mon_closing) begin
                    mon_nw.data = '0;
                    for (int i = 0; i < part_q.size(); i++)
                        mon_nw.data[i*WIDTH +: WIDTH] = part_q[i];
                    mon_nw.keep = RATIO'((1 << part_q.size()) - 1);
                    mon_nw.last = in_last;
                    exp_q.push_back(mon_nw);
                    part_q.delete();
                end
            end
        end
    end

    // Offer one beat, hold it until accepted (bounded), return 1 ns after
    // the accepting edge with in_valid dropped.
    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 1000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: beat %h not accepted after %0d cycles", d, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_keep",  64'(out_keep),  64'(0));
        chk("rst_out_last",  64'(out_last),  64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        @(posedge clk);
        #1;

        // ---------------- pack ----------------
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        @(negedge clk);
        chk("pack_valid", 64'(out_valid), 64'(1));
        chk("pack_data",  64'(out_data),  64'(32'h44332211));
        chk("pack_keep",  64'(out_keep),  64'(4'b1111));
        chk("pack_last",  64'(out_last),  64'(0));
        @(negedge clk);
        chk("pack_one_cycle", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // ---------------- early last ----------------
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        @(negedge clk);
        chk("early_data", 64'(out_data), 64'(32'h0000A2A1));
        chk("early_keep", 64'(out_keep), 64'(4'b0011));
        chk("early_last", 64'(out_last), 64'(1));
        @(posedge clk);
        #1;

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h08;
        in_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'(0));
            chk("bp_hold_data",    64'(out_data), 64'(32'h04030201));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_word2_valid", 64'(out_valid), 64'(1));
        chk("bp_word2_data",  64'(out_data),  64'(32'h08070605));
        @(posedge clk);
        #1;

        // ---------------- single-beat words ----------------
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            in_last  = 1'b1;
            @(negedge clk);
            chk("single_in_ready", 64'(in_ready), 64'(1));
            if (i > 0) begin
                chk("single_valid", 64'(out_valid), 64'(1));
                chk("single_keep",  64'(out_keep),  64'(4'b0001));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("single_last_data", 64'(out_data), 64'(32'h000000C4));
        @(posedge clk);
        #1;

        // ---------------- reset mid-word ----------------
        out_ready = 1'b0;
        send(8'h5A, 1'b1);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_data",  64'(out_data),  64'(0));
        chk("mid_rst_keep",  64'(out_keep),  64'(0));
        chk("mid_rst_last",  64'(out_last),  64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        send(8'h74, 1'b0);
        @(negedge clk);
        chk("post_rst_data", 64'(out_data), 64'(32'h74737271));
        chk("post_rst_keep", 64'(out_keep), 64'(4'b1111));
        @(posedge clk);
        #1;

        // ---------------- random soak ----------------
        fork
            begin
                for (int b = 0; b < 10000; b++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        send(8'hEE, 1'b1);
        repeat (3) @(negedge clk);
        chk("drain_empty", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/handshake_pack_block.md
# handshake_pack_block

Downstream consumer of the valid/ready pipeline stages: packs a stream of narrow WIDTH-bit beats into RATIO-lane wide words. It sits between a pipelined narrow stream and a wide sink such as a memory write port or a wide FIFO. It supports early termination via a last flag. A keep mask marks the valid lanes, and the output is fully registered.

## Interface
- WIDTH, 32, narrow beat width in bits
- RATIO, 4, lanes per wide word; legal range 2..64
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  narrow beat valid
- in_ready  output  1  narrow beat accepted when in_valid && in_ready
- in_data  input  WIDTH  narrow beat payload
- in_last  input  1  beat closes the current wide word regardless of fill level
- out_valid  output  1  wide word valid
- out_ready  input  1  wide word consumed when out_valid && out_ready
- out_data  output  WIDTH*RATIO  lane k at bits [k*WIDTH +: WIDTH]; lane 0 = first beat
- out_keep  output  RATIO  bit k set iff lane k holds a received beat
- out_last  output  1  word was closed by in_last

## Operation
- State:
  - accumulator acc (RATIO-1 lanes of WIDTH)
  - fill counter cnt, 0..RATIO-1, width $clog2(RATIO)
  - output register {out_data, out_keep, out_last, out_valid}
- slot_free = !out_valid || out_ready.
- closing = (cnt == RATIO-1) || in_last.
- in_ready = slot_free || !closing.
  - in_ready is combinational in out_valid, out_ready, cnt and in_last.
  - in_ready never depends on in_valid.
- Accepted non-closing beat:
  - in_data is written to acc lane cnt.
  - cnt increments.
  - The output register is untouched.
- Accepted closing beat:
  - out_data lanes 0..cnt-1 take acc, lane cnt takes in_data, and lanes above cnt are driven 0.
  - out_keep = (2^(cnt+1))-1.
  - out_last = in_last.
  - out_valid is set.
  - cnt returns to 0.
- Full word with in_last set (cnt == RATIO-1 and in_last): out_keep is all ones and out_last = 1.
- Output consumed with no new closing beat: out_valid clears. out_data, out_keep and out_last hold their stale values.
- Consume and close in the same cycle: the new word replaces the old one and out_valid stays 1, so there is no bubble.
- acc lanes at or above cnt are don't-care internally and must never leak to out_data.
- No data is dropped or duplicated. Beats leave in arrival order, lane-ascending.

## Timing
- Reset (async assert, sync-safe release) forces:
  - cnt = 0
  - acc = 0
  - out_valid = 0, out_data = 0, out_keep = 0, out_last = 0
- Reset mid-word discards the partial word and any pending output word.
- in_ready is 1 out of reset.
- Latency: a closing beat accepted at edge N gives out_valid = 1 after edge N, so the word is visible in cycle N+1.
- Throughput:
  - One wide word per RATIO accepted beats at sustained out_ready = 1.
  - One word per cycle when every beat has in_last = 1.
- Backpressure when out_valid && !out_ready:
  - Up to RATIO-1 further non-closing beats are still accepted.
  - in_ready drops only for a closing beat.
- out_* are stable while out_valid && !out_ready (AXI-style).
- The upstream must hold in_data and in_last stable while in_valid && !in_ready.

## Test plan
- **Pack** (WIDTH=8, RATIO=4, out_ready=1): beats 0x11, 0x22, 0x33, 0x44, in_last=0, back-to-back.
  - One cycle after the 4th beat: out_data=0x44332211, out_keep=4'b1111, out_last=0.
  - out_valid is high for exactly 1 cycle.
  - in_ready stays 1 throughout.
- **Early last**: beats 0xA1, 0xA2 with the second beat's in_last=1.
  - out_data=0x0000A2A1, out_keep=4'b0011, out_last=1.
  - The next word restarts at lane 0.
- **Backpressure**: out_ready=0 after the first word, then 8 beats are offered continuously.
  - Beats 5-7 are accepted; in_ready=0 on beat 8 only.
  - The first word is held unchanged.
  - Raising out_ready gives both words in order with no lost or duplicated beats.
- **Single-beat words**: 5 consecutive beats with in_last=1 at out_ready=1.
  - 5 consecutive output cycles.
  - Each word has out_keep=4'b0001 and out_last=1.
- **Reset mid-word**: rst pulsed after 2 beats.
  - All outputs go to 0 immediately (async).
  - The next 4 beats form a clean word with lane 0 = first beat after reset.
- **Random soak**: random in_valid/out_ready/in_last over 10k beats; a scoreboard checks:
  - order and keep masks
  - out_* stable during stalls
  - no out_valid before the first closing beat
